// File: rtl/muldiv_pkg.sv
// Shared ALU control codes, FSM state encoding and default datapath width
// for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] MULT  = 4'd8;
    localparam logic [3:0] MULTU = 4'd9;
    localparam logic [3:0] DIV   = 4'd10;
    localparam logic [3:0] DIVU  = 4'd11;
    localparam logic [3:0] MTHI  = 4'd12;
    localparam logic [3:0] MTLO  = 4'd13;
    localparam logic [3:0] MADD  = 4'd14;
    localparam logic [3:0] MADDU = 4'd15;
    localparam logic [3:0] MSUB  = 4'd6;
    localparam logic [3:0] MSUBU = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iteration datapath: one shift-add (multiply) or restoring
// trial-subtract (divide) step per i_step; {o_hi,o_lo} hold product or {rem,quo}.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_div,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_opnd,
    input  logic [WIDTH-1:0] i_init_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic             r_div;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic             w_fit;
    logic [WIDTH-1:0] w_sub;

    // Multiply: conditionally add multiplicand into the upper half, then shift the
    // whole 2*WIDTH register right, pulling the carry in at the top.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: remainder lives in r_hi, dividend/quotient shifts through r_lo.
    // When the trial fits the difference is below the divisor, so WIDTH bits suffice.
    assign w_shl = {r_hi, r_lo[WIDTH-1]};
    assign w_fit = (w_shl >= {1'b0, r_opnd});
    assign w_sub = w_shl[WIDTH-1:0] - r_opnd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= 1'b0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_opnd <= i_opnd;
            r_hi   <= '0;
            r_lo   <= i_init_lo;
        end else if (i_step) begin
            if (r_div) begin
                r_hi <= w_fit ? w_sub : w_shl[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_fit};
            end else begin
                r_hi <= w_add[WIDTH:1];
                r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS mult/div with HI/LO, Start/Busy/Done handshake, WIDTH+1 edge latency.
// Optional MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate into {Hi,Lo}.
module mult_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_is_div;
    logic               r_p_neg;
    logic               r_q_neg;
    logic               r_r_neg;

    logic               w_idle_req;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_accept;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_idle_req = Start && (r_state == IDLE);
    assign w_is_div   = (ALUOp == DIV) || (ALUOp == DIVU);
    assign w_mthi     = w_idle_req && (ALUOp == MTHI);
    assign w_mtlo     = w_idle_req && (ALUOp == MTLO);

`ifdef MULDIV_MADD_EN
    logic r_acc;
    logic r_sub;
    logic w_acc;
    logic w_sub;

    assign w_acc    = (ALUOp == MADD) || (ALUOp == MADDU) || (ALUOp == MSUB) || (ALUOp == MSUBU);
    assign w_sub    = (ALUOp == MSUB) || (ALUOp == MSUBU);
    assign w_is_mul = (ALUOp == MULT) || (ALUOp == MULTU) || w_acc;
    assign w_signed = (ALUOp == MULT) || (ALUOp == DIV) || (ALUOp == MADD) || (ALUOp == MSUB);
`else
    assign w_is_mul = (ALUOp == MULT) || (ALUOp == MULTU);
    assign w_signed = (ALUOp == MULT) || (ALUOp == DIV);
`endif

    assign w_accept = w_idle_req && (w_is_mul || w_is_div);
    assign w_a_neg  = w_signed && A[WIDTH-1];
    assign w_b_neg  = w_signed && B[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -A : A;
    assign w_b_abs  = w_b_neg ? -B : B;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_load    (w_accept),
        .i_div     (w_is_div),
        .i_step    (r_state == RUN),
        .i_opnd    (w_is_div ? w_b_abs : w_a_abs),
        .i_init_lo (w_is_div ? w_a_abs : w_b_abs),
        .o_hi      (w_core_hi),
        .o_lo      (w_core_lo)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = r_p_neg ? -w_prod : w_prod;
    assign w_quo      = r_q_neg ? -w_core_lo : w_core_lo;
    assign w_rem      = r_r_neg ? -w_core_hi : w_core_hi;

`ifdef MULDIV_MADD_EN
    assign w_mul_res = !r_acc ? w_prod_fix :
                       r_sub  ? ({r_hi, r_lo} - w_prod_fix) : ({r_hi, r_lo} + w_prod_fix);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_acc <= 1'b0;
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc;
            r_sub <= w_sub;
        end
    end
`else
    assign w_mul_res = w_prod_fix;
`endif

    // Divide-by-zero yields an all-ones quotient from the core; suppressing the
    // quotient negation keeps it all ones, and the sign-restored remainder is raw A.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_p_neg  <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (w_accept) begin
                r_cnt    <= '0;
                r_is_div <= w_is_div;
                r_p_neg  <= w_a_neg ^ w_b_neg;
                r_q_neg  <= (w_a_neg ^ w_b_neg) && (B != '0);
                r_r_neg  <= w_a_neg;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == FIX) begin
                if (r_is_div) begin
                    r_lo <= w_quo;
                    r_hi <= w_rem;
                end else begin
                    {r_hi, r_lo} <= w_mul_res;
                end
            end else if (w_mthi) begin
                r_hi <= A;
            end else if (w_mtlo) begin
                r_lo <= A;
            end
        end
    end

    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Busy = (r_state != IDLE);
    assign Done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected Hi/Lo queued at issue, checked at Done.
module tb_mult_div_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .ALUOp (ALUOp),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single edge, queue its expectation, then scramble A/B.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        exp_t e;
        e.tag = tag;
        e.hi  = ehi;
        e.lo  = elo;
        ALUOp = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        sb.push_back(e);
        tick();
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        chk({tag, "_busy"}, {63'd0, Busy}, 64'd1);
    endtask

    // Wait (bounded) for Done; Hi/Lo must hold until then.
    task automatic retire(input int exp_lat);
        exp_t        e;
        int          lat = 0;
        int          moved = 0;
        logic [31:0] hold_hi = Hi;
        logic [31:0] hold_lo = Lo;
        while (lat < 60) begin
            tick();
            lat++;
            if (Done === 1'b1) break;
            if (Hi !== hold_hi || Lo !== hold_lo) moved++;
        end
        e = sb.pop_front();
        chk({e.tag, "_lat"},    64'(lat),   64'(exp_lat));
        chk({e.tag, "_stable"}, 64'(moved), 64'd0);
        chk({e.tag, "_hi"},     {32'd0, Hi}, {32'd0, e.hi});
        chk({e.tag, "_lo"},     {32'd0, Lo}, {32'd0, e.lo});
        chk({e.tag, "_idle"},   {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rp;
        int          dones;

        Reset = 1'b1;
        Start = 1'b0;
        ALUOp = 4'd0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        chk("rst_hi",   {32'd0, Hi},   64'd0);
        chk("rst_lo",   {32'd0, Lo},   64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        Reset = 1'b0;
        tick();

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        retire(33);
        tick();
        chk("done_pulse", {63'd0, Done}, 64'd0);

        issue(MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        retire(33);

        // Second request issued in the Done cycle: back-to-back acceptance.
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        retire(33);
        issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_b2b");
        retire(33);

        issue(DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero");
        retire(33);
        issue(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero");
        retire(33);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        retire(33);

        ALUOp = MTHI; A = 32'hDEAD_BEEF; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("mthi_hi",   {32'd0, Hi},   64'hDEAD_BEEF);
        chk("mthi_busy", {63'd0, Busy}, 64'd0);
        chk("mthi_done", {63'd0, Done}, 64'd0);
        ALUOp = MTLO; A = 32'h0BAD_F00D; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("mtlo_lo",   {32'd0, Lo},   64'h0BAD_F00D);
        chk("mtlo_hi",   {32'd0, Hi},   64'hDEAD_BEEF);
        ALUOp = 4'd0; A = 32'h1111_1111; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("other_busy", {63'd0, Busy}, 64'd0);
        chk("other_lo",   {32'd0, Lo},   64'h0BAD_F00D);

        issue(MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "mtlo_busy");
        ALUOp = MTLO; A = 32'h0000_0055; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("mtlo_busy_lo", {32'd0, Lo}, 64'h0BAD_F00D);
        retire(32);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = 64'($signed(ra)) * 64'($signed(rb));
            issue(MULT, ra, rb, rp[63:32], rp[31:0], "mult_rand");
            retire(33);
            rb = rb >> (i * 8);
            if (rb == 0) rb = 32'd1;
            issue(DIVU, ra, rb, ra % rb, ra / rb, "divu_rand");
            retire(33);
        end

        issue(MULTU, 32'd9, 32'd9, 32'd0, 32'd81, "rst_mid");
        repeat (9) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        void'(sb.pop_back());
        chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
        chk("rst_mid_hi",   {32'd0, Hi},   64'd0);
        chk("rst_mid_lo",   {32'd0, Lo},   64'd0);
        chk("rst_mid_done", {63'd0, Done}, 64'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (Done === 1'b1) dones++;
        end
        chk("rst_mid_nodone", 64'(dones), 64'd0);

        issue(MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "multu_after_rst");
        retire(33);

`ifdef MULDIV_MADD_EN
        issue(MADDU, 32'd2, 32'd3, 32'd0, 32'd36, "maddu");
        retire(33);
        issue(MSUB, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd37, "msub_neg");
        retire(33);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
